// File: rtl/spi_rx.sv
// SPI slave receiver: oversamples SCK/CS/MOSI on i_clk and shifts in WIDTH-bit words in any CKP/CPH mode.
// A response word is shifted out on o_miso across the same frame.
module spi_rx #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sck,
  input  logic             i_cs_n,
  input  logic             i_mosi,
  input  logic             i_ckp,
  input  logic             i_cph,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_miso,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACTIVE} state_t;
  state_t r_state, w_next;

  logic             r_sck_s1, r_sck_s2, r_sck_s3;
  logic             r_cs_s1, r_cs_s2, r_cs_s3;
  logic             r_mosi_s1, r_mosi_s2;
  logic             r_ckp, r_cph;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rx_sr, r_tx_sr, r_rx_data;
  logic             r_rx_valid;

  logic w_cs_fall, w_sck_rise, w_sck_fall, w_samp, w_shift, w_wrap;

  // Third stage on SCK/CS only feeds edge detection; MOSI aligns with the second stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= '0;
      {r_cs_s1, r_cs_s2, r_cs_s3}    <= '0;
      {r_mosi_s1, r_mosi_s2}         <= '0;
    end else begin
      {r_sck_s1, r_sck_s2, r_sck_s3} <= {i_sck, r_sck_s1, r_sck_s2};
      {r_cs_s1, r_cs_s2, r_cs_s3}    <= {i_cs_n, r_cs_s1, r_cs_s2};
      {r_mosi_s1, r_mosi_s2}         <= {i_mosi, r_mosi_s1};
    end
  end

  assign w_cs_fall  = r_cs_s3 & ~r_cs_s2;
  assign w_sck_rise = ~r_sck_s3 & r_sck_s2;
  assign w_sck_fall = r_sck_s3 & ~r_sck_s2;
  assign w_samp     = (r_ckp == r_cph) ? w_sck_rise : w_sck_fall;
  assign w_shift    = (r_ckp == r_cph) ? w_sck_fall : w_sck_rise;
  assign w_wrap     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_cs_fall) w_next = S_LOAD;
      S_LOAD:   w_next = S_ACTIVE;
      S_ACTIVE: if (r_cs_s2) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ckp      <= 1'b0;
      r_cph      <= 1'b0;
      r_cnt      <= '0;
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_cs_fall) begin
            r_ckp <= i_ckp;
            r_cph <= i_cph;
          end
        end
        S_LOAD: begin
          r_tx_sr <= i_tx_data;
          r_rx_sr <= '0;
          r_cnt   <= '0;
        end
        S_ACTIVE: begin
          // CS deassertion wins over a coincident SCK edge; a partial word is dropped.
          if (r_cs_s2) begin
            r_cnt <= '0;
          end else if (w_samp) begin
            r_rx_sr <= {r_rx_sr[WIDTH-2:0], r_mosi_s2};
            r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) begin
              r_rx_data  <= {r_rx_sr[WIDTH-2:0], r_mosi_s2};
              r_rx_valid <= 1'b1;
              r_tx_sr    <= i_tx_data;
            end
          end else if (w_shift && r_cnt != '0) begin
            r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_busy     = (r_state == S_ACTIVE);
  assign o_miso     = o_busy & r_tx_sr[WIDTH-1];
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: a behavioural SPI master drives frames in all four modes,
// and a monitor logs every RX_VALID strobe for comparison against hand-computed words.
module tb_spi_rx;
  logic       clk, rst_n;
  logic       sck, cs_n, mosi, ckp, cph;
  logic [7:0] tx_data;
  logic       miso, rx_valid, busy;
  logic [7:0] rx_data;

  int         ntests, nfail, vcnt;
  logic [7:0] vq[$];
  logic [15:0] mo;
  int         n0;

  spi_rx #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sck(sck), .i_cs_n(cs_n), .i_mosi(mosi),
    .i_ckp(ckp), .i_cph(cph), .i_tx_data(tx_data),
    .o_miso(miso), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      vq.push_back(rx_data);
      vcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master: bit i on the wire is d[nbits-1-i]; MISO bits collected MSB first into mo.
  task automatic xfer(input logic m_ckp, input logic m_cph, input logic [15:0] d,
                      input int nbits, input bit tog, input bit keep,
                      output logic [15:0] mo_o);
    mo_o = '0;
    ckp = m_ckp; cph = m_cph; sck = m_ckp;
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    if (!m_cph) mosi = d[nbits-1];
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sck = ~m_ckp;
      if (m_cph) mosi = d[nbits-1-i];
      else       mo_o = {mo_o[14:0], miso};
      repeat (4) @(negedge clk);
      sck = m_ckp;
      if (m_cph)             mo_o = {mo_o[14:0], miso};
      else if (i + 1 < nbits) mosi = d[nbits-2-i];
      if (tog && i == 3) ckp = ~ckp;
      repeat (4) @(negedge clk);
    end
    if (!keep) begin
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    ntests = 0; nfail = 0; vcnt = 0;
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; ckp = 1'b0; cph = 1'b0;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_miso", {31'd0, miso}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'h0);

    // Mode 0
    n0 = vcnt; tx_data = 8'h3C;
    xfer(1'b0, 1'b0, 16'h00A5, 8, 1'b0, 1'b0, mo);
    chk("m0_vcnt", vcnt - n0, 1);
    chk("m0_rx", {24'd0, vq[n0]}, 32'hA5);
    chk("m0_miso", {16'd0, mo}, 32'h3C);

    // Mode 3
    n0 = vcnt; tx_data = 8'hC3;
    xfer(1'b1, 1'b1, 16'h0065, 8, 1'b0, 1'b0, mo);
    chk("m3_vcnt", vcnt - n0, 1);
    chk("m3_rx", {24'd0, rx_data}, 32'h65);
    chk("m3_miso", {16'd0, mo}, 32'hC3);

    // Modes 1 and 2, two words per frame
    for (int m = 1; m <= 2; m++) begin
      n0 = vcnt; tx_data = 8'hF0;
      xfer(m == 2, m == 1, 16'h1234, 16, 1'b0, 1'b0, mo);
      chk($sformatf("m%0d_vcnt", m), vcnt - n0, 2);
      chk($sformatf("m%0d_w0", m), {24'd0, vq[n0]}, 32'h12);
      chk($sformatf("m%0d_w1", m), {24'd0, vq[n0+1]}, 32'h34);
      chk($sformatf("m%0d_miso", m), {16'd0, mo}, 32'hF0F0);
    end

    // Abort after 5 bits of the second word
    n0 = vcnt; tx_data = 8'h99;
    xfer(1'b0, 1'b0, {3'b000, 8'h5A, 5'b10110}, 13, 1'b0, 1'b0, mo);
    chk("ab_vcnt", vcnt - n0, 1);
    chk("ab_rx", {24'd0, rx_data}, 32'h5A);
    chk("ab_busy", {31'd0, busy}, 32'h0);
    chk("ab_miso", {31'd0, miso}, 32'h0);
    n0 = vcnt;
    xfer(1'b0, 1'b0, 16'h0081, 8, 1'b0, 1'b0, mo);
    chk("ab_next_vcnt", vcnt - n0, 1);
    chk("ab_next_rx", {24'd0, rx_data}, 32'h81);

    // Asynchronous reset mid-frame, after bit 3
    tx_data = 8'hFF;
    xfer(1'b0, 1'b0, 16'h000B, 4, 1'b0, 1'b1, mo);
    chk("rm_busy_pre", {31'd0, busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_rx", {24'd0, rx_data}, 32'h0);
    chk("rm_busy", {31'd0, busy}, 32'h0);
    chk("rm_miso", {31'd0, miso}, 32'h0);
    chk("rm_valid", {31'd0, rx_valid}, 32'h0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n0 = vcnt;
    xfer(1'b0, 1'b0, 16'h00FF, 8, 1'b0, 1'b0, mo);
    chk("rm_next_vcnt", vcnt - n0, 1);
    chk("rm_next_rx", {24'd0, rx_data}, 32'hFF);

    // CKP toggled while CS is low; captured mode must be used
    n0 = vcnt; tx_data = 8'h5E;
    xfer(1'b0, 1'b0, 16'h00C7, 8, 1'b1, 1'b0, mo);
    chk("mc_vcnt", vcnt - n0, 1);
    chk("mc_rx", {24'd0, rx_data}, 32'hC7);
    chk("mc_miso", {16'd0, mo}, 32'h5E);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
